// File: rtl/arbiter_rr_n_if.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_rr_n_if
// Description : Request/grant bundle between the bus masters and the
//               N-way round-robin arbiter.
//                 req     - per-master request level
//                 finish  - per-master transaction-complete pulse
//                 gnt     - one-hot grant pulse (combinational)
//                 sel     - registered one-hot data-path select
//                 busy    - registered bus-owned flag
//                 owner   - registered owner index, valid while busy
//                 timeout - registered watchdog release pulse
//               Modport 'slave' is the arbiter side; 'master' is the
//               requester side.
// Revision    : 1.0 - initial release
// ============================================================================
interface arbiter_rr_n_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) ();
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] finish;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] sel;
    logic            busy;
    logic [IDW-1:0]  owner;
    logic            timeout;

    modport slave (
        input  req,
        input  finish,
        output gnt,
        output sel,
        output busy,
        output owner,
        output timeout
    );

    modport master (
        output req,
        output finish,
        input  gnt,
        input  sel,
        input  busy,
        input  owner,
        input  timeout
    );
endinterface : arbiter_rr_n_if
`default_nettype wire

// File: rtl/arbiter_rr_n.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_rr_n
// Description : N-requester round-robin bus arbiter. Grants one master at a
//               time, holds the grant until the owner signals finish, then
//               hands the bus to the next requester in rotating order.
//               Optional hold-timeout watchdog enabled by defining the macro
//               ARB_TIMEOUT_EN.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - arbiter_rr_n_if.slave (req, finish, gnt, sel, busy,
//                       owner, timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_rr_n #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TMO_CYC = 256,
    parameter int TMO_W   = 9
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    arbiter_rr_n_if.slave   bus
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_owner;
    logic [NREQ-1:0] r_sel;

    logic [0:0]      w_state_nxt;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [IDW-1:0]  w_owner_nxt;
    logic [IDW-1:0]  w_start;
    logic [IDW-1:0]  w_win;
    logic            w_found;
    logic            w_take;
    logic            w_owner_ok;
    logic            w_ptr_ok;
    logic            w_fin_own;
    logic            w_expire;
    logic            w_release;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_sel_nxt;

    // One-hot decode; an out-of-range index decodes to all zeros.
    function automatic logic [NREQ-1:0] f_onehot(input logic [IDW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (idx == IDW'(j)) begin
                v[j] = 1'b1;
            end
        end
        return v;
    endfunction

    // (k + 1) mod NREQ
    function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] k);
        if (int'(k) >= NREQ - 1) begin
            return '0;
        end
        return k + 1'b1;
    endfunction

    // Round-robin search: each requester's rotational distance from the
    // start index is its priority; the smallest distance among asserted
    // requests wins. Returns {found, index}.
    function automatic logic [IDW:0] f_search(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  s);
        int             best;
        int             d;
        logic [IDW-1:0] win;
        best = NREQ;
        win  = '0;
        for (int j = 0; j < NREQ; j++) begin
            d = j - int'(s);
            if (d < 0) begin
                d = d + NREQ;
            end
            if (r[j] && (d < best)) begin
                best = d;
                win  = IDW'(j);
            end
        end
        return {(best < NREQ), win};
    endfunction

    assign w_owner_ok = (int'(r_owner) < NREQ);
    assign w_ptr_ok   = (int'(r_ptr) < NREQ);
    assign w_fin_own  = |(bus.finish & f_onehot(r_owner));
    assign w_release  = w_fin_own | w_expire;

    // While busy the search starts just past the owner, so the owner's own
    // renewed request is considered last.
    assign w_start = (r_state == c_BUSY) ? f_next(r_owner) : r_ptr;
    assign {w_found, w_win} = f_search(bus.req, w_start);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_take      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!w_ptr_ok) begin
                    w_ptr_nxt = '0;
                end else if (w_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = c_BUSY;
                    w_owner_nxt = w_win;
                end
            end
            c_BUSY: begin
                if (!w_owner_ok) begin
                    w_state_nxt = c_IDLE;
                    w_owner_nxt = '0;
                    w_ptr_nxt   = '0;
                end else if (w_release) begin
                    if (w_found) begin
                        // Back-to-back handoff, no idle cycle.
                        w_take      = 1'b1;
                        w_owner_nxt = w_win;
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_owner_nxt = '0;
                        w_ptr_nxt   = w_start;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_owner_nxt = '0;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign w_gnt     = w_take ? f_onehot(w_win) : '0;
    assign w_sel_nxt = (w_state_nxt == c_BUSY) ? f_onehot(w_owner_nxt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] r_cnt;
    logic             r_timeout;

    // A finish arriving in the expiry cycle takes precedence, so no timeout.
    assign w_expire = (r_state == c_BUSY) && w_owner_ok &&
                      (r_cnt == c_TMO_LAST) && !w_fin_own;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_take) begin
                r_cnt <= '0;
            end else if (r_state == c_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.timeout = r_timeout;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^{TMO_CYC, TMO_W};
    assign w_expire     = 1'b0;
    assign bus.timeout  = 1'b0;
`endif

    assign bus.gnt   = w_gnt;
    assign bus.sel   = r_sel;
    assign bus.busy  = (r_state == c_BUSY);
    assign bus.owner = r_owner;

endmodule : arbiter_rr_n
`default_nettype wire

// File: tb/tb_arbiter_rr_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_rr_n
// Description : Self-checking bench for arbiter_rr_n (NREQ=4, TMO_CYC=8).
//               Directed scenarios followed by randomized request/finish
//               traffic, all checked against a behavioural model of the
//               round-robin rules. Honours ARB_TIMEOUT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_rr_n;

    localparam int N   = 4;
    localparam int TMO = 8;

`ifdef ARB_TIMEOUT_EN
    localparam bit c_TMO_ON = 1'b1;
`else
    localparam bit c_TMO_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    arbiter_rr_n_if #(.NREQ(N), .IDW(2)) u_if ();

    arbiter_rr_n #(
        .NREQ    (N),
        .IDW     (2),
        .TMO_CYC (TMO),
        .TMO_W   (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    int       n_cmp = 0;
    int       n_err = 0;

    // Behavioural model state
    bit       m_busy;
    int       m_owner;
    int       m_ptr;
    int       m_cnt;
    bit       m_tmo;

    logic [3:0] last_gnt;
    logic [3:0] c_ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // First asserted request scanning start, start+1, ... modulo N.
    function automatic int pick(input logic [3:0] r, input int start);
        int c;
        for (int i = 0; i < N; i++) begin
            c = (start + i) % N;
            if (r[c[1:0]]) begin
                return c;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_tmo   = 1'b0;
    endtask

    // One clock cycle: apply inputs, check at negedge, advance model.
    task automatic cyc(input logic [3:0] r, input logic [3:0] f);
        logic [3:0] e_gnt;
        bit         n_busy;
        int         n_owner;
        int         n_ptr;
        int         n_cnt;
        bit         n_tmo;
        int         w;
        bit         own_fin;
        bit         exp_now;
        u_if.req    = r;
        u_if.finish = f;
        @(negedge clk);
        e_gnt   = 4'b0000;
        n_busy  = m_busy;
        n_owner = m_owner;
        n_ptr   = m_ptr;
        n_cnt   = m_cnt;
        n_tmo   = 1'b0;
        if (!m_busy) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                e_gnt   = 4'(1 << w);
                n_busy  = 1'b1;
                n_owner = w;
                n_cnt   = 0;
            end
        end else begin
            own_fin = f[m_owner[1:0]];
            exp_now = c_TMO_ON && (m_cnt == TMO - 1) && !own_fin;
            n_tmo   = exp_now;
            if (own_fin || exp_now) begin
                w = pick(r, (m_owner + 1) % N);
                if (w >= 0) begin
                    e_gnt   = 4'(1 << w);
                    n_owner = w;
                    n_cnt   = 0;
                end else begin
                    n_busy = 1'b0;
                    n_ptr  = (m_owner + 1) % N;
                end
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        chk("gnt", 32'(u_if.gnt), 32'(e_gnt));
        chk("sel", 32'(u_if.sel), m_busy ? 32'(1 << m_owner) : 32'd0);
        chk("busy", 32'(u_if.busy), 32'(m_busy));
        if (m_busy) begin
            chk("owner", 32'(u_if.owner), 32'(m_owner));
        end
        chk("timeout", 32'(u_if.timeout), 32'(m_tmo));
        last_gnt = u_if.gnt;
        @(posedge clk);
        #1;
        m_busy  = n_busy;
        m_owner = n_owner;
        m_ptr   = n_ptr;
        m_cnt   = n_cnt;
        m_tmo   = n_tmo;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(posedge clk);
        #1;
        u_if.req    = 4'b0000;
        u_if.finish = 4'b0000;
        rst_n       = 1'b0;
        #2;
        chk("rst_sel", 32'(u_if.sel), 32'd0);
        chk("rst_busy", 32'(u_if.busy), 32'd0);
        chk("rst_owner", 32'(u_if.owner), 32'd0);
        chk("rst_tmo", 32'(u_if.timeout), 32'd0);
        chk("rst_gnt", 32'(u_if.gnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] f;
        int         hit;
        u_if.req    = 4'b0000;
        u_if.finish = 4'b0000;
        model_reset();

        // Single request, grant, release to idle; ptr advances past owner.
        do_reset();
        cyc(4'b0100, 4'b0000);
        chk("t1_gnt", 32'(last_gnt), 32'h4);
        cyc(4'b0100, 4'b0000);
        chk("t1_owner", 32'(u_if.owner), 32'd2);
        cyc(4'b0000, 4'b0100);
        chk("t1_idle", 32'(u_if.busy), 32'd0);
        cyc(4'b1111, 4'b0000);
        chk("t1_ptr3", 32'(last_gnt), 32'h8);

        // All requesting, each finishes when granted: 0,1,2,3,0 back to back.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(4'b1111, m_busy ? 4'(1 << m_owner) : 4'b0000);
            chk("t2_order", 32'(last_gnt), 32'(c_ord[k]));
        end

        // Non-owner finish ignored, then owner finish hands off to 0.
        do_reset();
        cyc(4'b0010, 4'b0000);
        cyc(4'b0000, 4'b0001);
        chk("t3_nogate", 32'(last_gnt), 32'd0);
        chk("t3_sel", 32'(u_if.sel), 32'h2);
        cyc(4'b0011, 4'b0010);
        chk("t3_gnt", 32'(last_gnt), 32'h1);

        // Wrap-around from owner 3 to requester 0.
        do_reset();
        cyc(4'b1000, 4'b0000);
        cyc(4'b1001, 4'b1000);
        chk("t4_wrap", 32'(last_gnt), 32'h1);
        cyc(4'b1000, 4'b0001);
        chk("t4_after", 32'(last_gnt), 32'h8);

        // Reset mid-transaction, then fresh grant from ptr 0.
        do_reset();
        cyc(4'b1000, 4'b0000);
        cyc(4'b1000, 4'b0000);
        chk("t5_sel", 32'(u_if.sel), 32'h8);
        do_reset();
        cyc(4'b1000, 4'b0000);
        chk("t5_gnt", 32'(last_gnt), 32'h8);

        // Owner 0 never finishes.
        do_reset();
        cyc(4'b0001, 4'b0000);
        hit = 0;
        for (int i = 1; i <= 20 && hit == 0; i++) begin
            cyc(4'b0110, 4'b0000);
            if (last_gnt != 4'b0000) begin
                hit = i;
            end
        end
`ifdef ARB_TIMEOUT_EN
        chk("t6_cycles", 32'(hit), 32'd8);
        chk("t6_gnt", 32'(last_gnt), 32'h2);
        chk("t6_tmo", 32'(u_if.timeout), 32'd1);
`else
        chk("t6_hold", 32'(hit), 32'd0);
        chk("t6_owner", 32'(u_if.owner), 32'd0);
        chk("t6_tmo", 32'(u_if.timeout), 32'd0);
`endif

        // Randomized traffic; later phase finishes rarely to exercise the
        // watchdog, with occasional resets mid-transaction.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            f = 4'($urandom_range(0, 15));
            if (m_busy) begin
                f[m_owner[1:0]] = ($urandom_range(0, (c < 1500) ? 2 : 12) == 0);
            end
            cyc(4'($urandom_range(0, 15)), f);
            if ((c % 700) == 699) begin
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_arbiter_rr_n
`default_nettype wire

// File: doc/arbiter_rr_n.md
# arbiter_rr_n

Parametrised N-requester round-robin arbiter for the tiny AXI bus. It grants one master at a time, holds the grant until that master signals completion, then rotates priority to the next requester. Compared with the fixed three-way arbiter it adds:
- configurable channel count;
- per-owner finish qualification;
- an owner index output;
- an optional hold-timeout watchdog.

It sits between the bus masters (I-cache, D-cache, DMA, debug) and the shared slave-side mux.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of owner index; must satisfy 2**IDW >= NREQ.
- TMO_CYC, 256, watchdog hold limit in cycles (only used with ARB_TIMEOUT_EN).
- TMO_W, 9, watchdog counter width; must satisfy 2**TMO_W > TMO_CYC.

Ports:
- clk  input  1  system clock, all flops on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-master request, level, held until granted.
- finish  input  NREQ  per-master transaction-complete pulse.
- gnt  output  NREQ  one-hot grant pulse, one cycle, combinational.
- sel  output  NREQ  registered one-hot bus select for the data path.
- busy  output  1  registered, bus owned.
- owner  output  IDW  registered index of the current owner; valid while busy.
- timeout  output  1  registered one-cycle pulse when the watchdog forces a release.

## Operation
- Two-state FSM:
  - IDLE (busy=0).
  - BUSY (busy=1, owner=k).
- Priority pointer ptr (IDW bits):
  - The search order is ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - The first asserted req in that order wins.
- IDLE:
  - With no req, stay in IDLE.
  - Otherwise the winner w is computed from ptr, gnt[w]=1, and the next state is BUSY with owner=w.
- BUSY with owner k:
  - Release occurs when finish[k]=1, or on watchdog expiry.
  - finish[j] for j≠k is ignored.
  - No release: stay, gnt=0.
  - Release with any req asserted: search from (k+1) mod NREQ, with k itself last. gnt[w]=1 and the FSM stays BUSY with owner=w; this is a back-to-back handoff with no idle cycle.
  - Release with no req: go to IDLE and set ptr=(k+1) mod NREQ.
- gnt is asserted only when a new ownership starts, never while an owner is simply holding.
- sel is the registered one-hot of the next-state owner (zero when the next state is IDLE).
- Out-of-range owner or ptr values (NREQ not a power of two) decode to IDLE on the next cycle.
- Reset values: FSM=IDLE, ptr=0, owner=0, busy=0, sel=0, timeout=0, watchdog counter=0. gnt is 0 whenever req=0.

## Timing
- gnt is combinational from req, finish and state, in the same cycle.
- sel, busy and owner change on the edge after gnt (1-cycle latency), which matches the existing bus mux timing.
- On release without a new request, sel and busy drop on the edge after finish.
- On handoff, sel switches directly from k to w on that edge, with no zero cycle.
- A requester must keep req high until it sees gnt. Dropping req before gnt withdraws the request.
- A requester must deassert req, or start a new transaction, after its own finish.
- finish and a new req from the owner in the same cycle: the owner is lowest priority, so it regains the bus only if no other req is asserted.
- Reset is asynchronous. Asserting it mid-transaction clears all state immediately, and sel drops without a finish.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A TMO_W-bit counter clears on every gnt and increments each BUSY cycle.
  - If the count reaches TMO_CYC-1 with no finish[owner] in that cycle, a release is forced exactly as if finish[owner] had arrived, and timeout pulses on the next edge.
  - If finish and expiry coincide, finish wins and timeout stays 0.
- ARB_TIMEOUT_EN undefined:
  - No counter is built, timeout is tied 0, and release is only by finish[owner].

## Test plan
All scenarios use NREQ=4.
1. Reset, then req=4'b0100 → gnt=4'b0100 in the same cycle. Next edge: sel=4'b0100, owner=2, busy=1. finish=4'b0100 → on the next edge sel=0, busy=0, ptr=3.
2. All req=4'b1111, each master pulses its own finish once granted → grant order 0,1,2,3,0, with handoff and no idle cycle between grants.
3. Owner 1 holding, finish=4'b0001 (non-owner) → no gnt, sel stays 4'b0010. Then finish=4'b0010 with req=4'b0011 → gnt=4'b0001.
4. Owner 3 finishes and req=4'b1001 is held in the same cycle → gnt=4'b0001 (wrap-around). Master 3 is served next time only after 0.
5. rst_n asserted low mid-transaction with sel=4'b1000 → sel, busy and owner read 0 immediately. After release, req=4'b1000 is granted from ptr=0.
6. ARB_TIMEOUT_EN with TMO_CYC=8: owner 0 never finishes and req=4'b0110 → gnt=4'b0010 eight cycles after the original grant, and timeout is high for one cycle on the following edge. Without the macro, the bus is held indefinitely and timeout stays 0.
